// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle spacing between rising edges of pulse_in and flags a timeout
// after MAX_PERIOD cycles without an edge. Define PPM_SYNC_EN to add a 2-flop input synchronizer.
module pulse_period_meter #(
    parameter int W          = 16,
    parameter int MAX_PERIOD = 1000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         pulse_in,
    output logic [W-1:0] period,
    output logic         period_valid,
    output logic         timeout,
    output logic         busy
);

    localparam logic [W-1:0] MAX_CNT = W'(MAX_PERIOD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] period_q, period_d;
    logic         valid_q, valid_d;
    logic         timeout_q, timeout_d;
    logic         busy_q, busy_d;
    logic         pulse_d_q, pulse_d_d;
    logic         pulse_s;
    logic         rise;

`ifdef PPM_SYNC_EN
    logic sync1_q, sync2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pulse_in;
            sync2_q <= sync1_q;
        end
    end

    assign pulse_s = sync2_q;
`else
    assign pulse_s = pulse_in;
`endif

    // Edge detect: the delay flop resets high so a level already high at reset release is not an edge.
    assign pulse_d_d = pulse_s;
    assign rise      = pulse_s & ~pulse_d_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (!en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    if (rise) begin
                        state_d = MEASURE;
                        cnt_d   = W'(1);
                    end
                end
                MEASURE: begin
                    // A rise coinciding with cnt==MAX_CNT still reports a period.
                    if (rise) begin
                        period_d = cnt_q;
                        valid_d  = 1'b1;
                        cnt_d    = W'(1);
                    end else if (cnt_q == MAX_CNT) begin
                        state_d   = TIMEOUT;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + W'(1);
                    end
                end
                TIMEOUT: begin
                    timeout_d = 1'b1;
                    if (rise) begin
                        state_d   = MEASURE;
                        cnt_d     = W'(1);
                        timeout_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            pulse_d_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            pulse_d_q <= pulse_d_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Directed bench for pulse_period_meter (default build, no input synchronizer), MAX_PERIOD=20.
module tb_pulse_period_meter;

    localparam int W    = 16;
    localparam int MAXP = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         pulse_in;
    logic [W-1:0] period;
    logic         period_valid;
    logic         timeout;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pulse_period_meter #(.W(W), .MAX_PERIOD(MAXP)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .pulse_in     (pulse_in),
        .period       (period),
        .period_valid (period_valid),
        .timeout      (timeout),
        .busy         (busy)
    );

    // Packed views as {valid, timeout, busy, period}.
    function automatic logic [W+2:0] obs();
        return {period_valid, timeout, busy, period};
    endfunction

    function automatic logic [W+2:0] ex(input logic v, input logic t, input logic b, input int p);
        return {v, t, b, W'(p)};
    endfunction

    task automatic step(input logic p);
        pulse_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        en = 1'b0;
        step(1'b0);
        en = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; pulse_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (obs() !== ex(0, 0, 0, 0)) begin
            mismatched++;
            $display("FAIL reset: got %h expected %h (valid,timeout,busy,period)", obs(), ex(0, 0, 0, 0));
        end
        pulse_in = 1'b1; en = 1'b1; rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b1);
            compared++;
            if (obs() !== ex(0, 0, 0, 0)) begin
                mismatched++;
                $display("FAIL release_high k=%0d: got %h expected %h", k, obs(), ex(0, 0, 0, 0));
            end
        end
        step(1'b0);
        step(1'b1);
        compared++;
        if (obs() !== ex(0, 0, 1, 0)) begin
            mismatched++;
            $display("FAIL first_rise: got %h expected %h", obs(), ex(0, 0, 1, 0));
        end
    endtask

    task automatic test_div10();
        go_idle();
        for (int n = 0; n < 5; n++) begin
            step(1'b1);
            compared++;
            if (obs() !== ex(n > 0, 0, 1, (n > 0) ? 10 : 0)) begin
                mismatched++;
                $display("FAIL div10_rise n=%0d: got %h expected %h", n, obs(), ex(n > 0, 0, 1, (n > 0) ? 10 : 0));
            end
            for (int k = 0; k < 9; k++) begin
                step(1'b0);
                compared++;
                if (obs() !== ex(0, 0, 1, (n > 0) ? 10 : 0)) begin
                    mismatched++;
                    $display("FAIL div10_gap n=%0d k=%0d: got %h expected %h", n, k, obs(), ex(0, 0, 1, (n > 0) ? 10 : 0));
                end
            end
        end
    endtask

    task automatic test_change();
        int spacing [5] = '{10, 10, 7, 7, 7};
        int prev = 10;
        go_idle();
        step(1'b1);
        compared++;
        if (obs() !== ex(0, 0, 1, prev)) begin
            mismatched++;
            $display("FAIL change_first: got %h expected %h", obs(), ex(0, 0, 1, prev));
        end
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < spacing[i] - 1; k++) begin
                step(1'b0);
                compared++;
                if (obs() !== ex(0, 0, 1, prev)) begin
                    mismatched++;
                    $display("FAIL change_gap i=%0d k=%0d: got %h expected %h", i, k, obs(), ex(0, 0, 1, prev));
                end
            end
            step(1'b1);
            prev = spacing[i];
            compared++;
            if (obs() !== ex(1, 0, 1, prev)) begin
                mismatched++;
                $display("FAIL change_rise i=%0d: got %h expected %h", i, obs(), ex(1, 0, 1, prev));
            end
        end
    endtask

    task automatic test_timeout();
        go_idle();
        step(1'b1);
        repeat (4) step(1'b0);
        step(1'b1);
        compared++;
        if (obs() !== ex(1, 0, 1, 5)) begin
            mismatched++;
            $display("FAIL timeout_pre: got %h expected %h", obs(), ex(1, 0, 1, 5));
        end
        for (int k = 1; k <= 25; k++) begin
            step(1'b0);
            compared++;
            if (obs() !== ex(0, k >= MAXP, 1, 5)) begin
                mismatched++;
                $display("FAIL timeout_wait k=%0d: got %h expected %h", k, obs(), ex(0, k >= MAXP, 1, 5));
            end
        end
        step(1'b1);
        compared++;
        if (obs() !== ex(0, 0, 1, 5)) begin
            mismatched++;
            $display("FAIL timeout_clear: got %h expected %h", obs(), ex(0, 0, 1, 5));
        end
        repeat (9) step(1'b0);
        step(1'b1);
        compared++;
        if (obs() !== ex(1, 0, 1, 10)) begin
            mismatched++;
            $display("FAIL timeout_recover: got %h expected %h", obs(), ex(1, 0, 1, 10));
        end
    endtask

    task automatic test_boundary();
        go_idle();
        step(1'b1);
        for (int r = 0; r < 3; r++) begin
            for (int k = 1; k < MAXP; k++) begin
                step(1'b0);
                compared++;
                if (obs() !== ex(0, 0, 1, (r == 0) ? 10 : MAXP)) begin
                    mismatched++;
                    $display("FAIL boundary_gap r=%0d k=%0d: got %h expected %h", r, k, obs(), ex(0, 0, 1, (r == 0) ? 10 : MAXP));
                end
            end
            step(1'b1);
            compared++;
            if (obs() !== ex(1, 0, 1, MAXP)) begin
                mismatched++;
                $display("FAIL boundary_rise r=%0d: got %h expected %h", r, obs(), ex(1, 0, 1, MAXP));
            end
        end
    endtask

    task automatic test_rst_mid();
        go_idle();
        step(1'b1);
        repeat (2) step(1'b0);
        step(1'b1);
        compared++;
        if (obs() !== ex(1, 0, 1, 3)) begin
            mismatched++;
            $display("FAIL rst_pre: got %h expected %h", obs(), ex(1, 0, 1, 3));
        end
        repeat (5) step(1'b0);
        #2 rst = 1'b1;
        #1;
        compared++;
        if (obs() !== ex(0, 0, 0, 0)) begin
            mismatched++;
            $display("FAIL rst_async: got %h expected %h", obs(), ex(0, 0, 0, 0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0);
        compared++;
        if (obs() !== ex(0, 0, 0, 0)) begin
            mismatched++;
            $display("FAIL rst_after: got %h expected %h", obs(), ex(0, 0, 0, 0));
        end
    endtask

    task automatic test_en_drop();
        go_idle();
        step(1'b1);
        repeat (2) step(1'b0);
        step(1'b1);
        repeat (5) step(1'b0);
        en = 1'b0;
        step(1'b0);
        compared++;
        if (obs() !== ex(0, 0, 0, 3)) begin
            mismatched++;
            $display("FAIL en_drop: got %h expected %h", obs(), ex(0, 0, 0, 3));
        end
        step(1'b1);
        compared++;
        if (obs() !== ex(0, 0, 0, 3)) begin
            mismatched++;
            $display("FAIL rise_disabled: got %h expected %h", obs(), ex(0, 0, 0, 3));
        end
        step(1'b0);
        en = 1'b1;
        step(1'b1);
        compared++;
        if (obs() !== ex(0, 0, 1, 3)) begin
            mismatched++;
            $display("FAIL rise_after_en: got %h expected %h", obs(), ex(0, 0, 1, 3));
        end
        repeat (3) step(1'b0);
        step(1'b1);
        compared++;
        if (obs() !== ex(1, 0, 1, 4)) begin
            mismatched++;
            $display("FAIL en_remeasure: got %h expected %h", obs(), ex(1, 0, 1, 4));
        end
        repeat (MAXP) step(1'b0);
        compared++;
        if (obs() !== ex(0, 1, 1, 4)) begin
            mismatched++;
            $display("FAIL en_timeout: got %h expected %h", obs(), ex(0, 1, 1, 4));
        end
        en = 1'b0;
        step(1'b0);
        compared++;
        if (obs() !== ex(0, 0, 0, 4)) begin
            mismatched++;
            $display("FAIL en_drop_timeout: got %h expected %h", obs(), ex(0, 0, 0, 4));
        end
        en = 1'b1;
    endtask

    task automatic test_held_high();
        go_idle();
        step(1'b1);
        compared++;
        if (obs() !== ex(0, 0, 1, 4)) begin
            mismatched++;
            $display("FAIL held_rise: got %h expected %h", obs(), ex(0, 0, 1, 4));
        end
        for (int k = 1; k < 50; k++) begin
            step(1'b1);
            compared++;
            if (obs() !== ex(0, k >= MAXP, 1, 4)) begin
                mismatched++;
                $display("FAIL held_high k=%0d: got %h expected %h", k, obs(), ex(0, k >= MAXP, 1, 4));
            end
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0);
            compared++;
            if (obs() !== ex(0, 1, 1, 4)) begin
                mismatched++;
                $display("FAIL held_low k=%0d: got %h expected %h", k, obs(), ex(0, 1, 1, 4));
            end
        end
    endtask

    initial begin
        test_reset();
        test_div10();
        test_change();
        test_timeout();
        test_boundary();
        test_rst_mid();
        test_en_drop();
        test_held_high();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
